// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, state encoding and hex-to-segment table for the digit scanner
package seg_pkg;
  localparam int N_DIG = 8;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  typedef enum logic {ST_BLANK, ST_SHOW} state_t;
  localparam logic [15:0][7:0] SEG_TAB = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
endpackage

// File: rtl/seg_decoder.sv
// seg_decoder: 5-bit {dp, hex} value to active-low {dp,g,f,e,d,c,b,a}
module seg_decoder
  import seg_pkg::*;
(
  input  logic [4:0] val,
  output logic [7:0] seg
);
  logic [7:0] raw;
  assign raw = SEG_TAB[val[3:0]];
  assign seg = {raw[7] & ~val[4], raw[6:0]};
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit multiplexed display scanner with dead-time blanking and frame-synchronous buffer swap
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [4:0]       wr_data,
  input  logic             commit,
  input  logic [N_DIG-1:0] digit_en,
  output logic [N_DIG-1:0] DIG,
  output logic [7:0]       Y,
  output logic             commit_pending,
  output logic             frame_done
);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int BW = BLANK_CYC > 1 ? $clog2(BLANK_CYC) : 1;
  state_t state, state_n;
  logic [2:0] idx;
  logic [SW-1:0] scnt;
  logic [BW-1:0] bcnt;
  logic [4:0] shadow [N_DIG];
  logic [4:0] active [N_DIG];
  logic [7:0] seg;
  logic show_end, blank_end, boundary, lit;
  seg_decoder u_dec (.val(active[idx]), .seg(seg));
  assign show_end  = state == ST_SHOW && scnt == SW'(SCAN_DIV - 1);
  assign blank_end = state == ST_BLANK && bcnt == BW'(BLANK_CYC - 1);
  assign boundary  = show_end && idx == 3'd7;
  assign lit       = state == ST_SHOW && digit_en[idx];
  always_comb begin
    state_n = state;
    state_n = blank_end ? ST_SHOW : show_end ? ST_BLANK : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_BLANK;
      idx            <= '0;
      scnt           <= '0;
      bcnt           <= '0;
      commit_pending <= 1'b0;
      frame_done     <= 1'b0;
      DIG            <= SEG_OFF;
      Y              <= SEG_OFF;
      for (int i = 0; i < N_DIG; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      state <= state_n;
      scnt  <= (state == ST_SHOW && !show_end) ? scnt + 1'b1 : '0;
      bcnt  <= (state == ST_BLANK && !blank_end) ? bcnt + 1'b1 : '0;
      if (show_end) idx <= idx + 3'd1;
      frame_done <= boundary;
      // a commit landing on the boundary itself survives the clear and waits a frame
      commit_pending <= commit | (commit_pending & ~boundary);
      if (boundary && commit_pending) active <= shadow;
      if (wr_en) shadow[wr_addr] <= wr_data;
      DIG <= lit ? ~(8'b1 << idx) : SEG_OFF;
      Y   <= lit ? seg : SEG_OFF;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: frame-arithmetic reference model with directed, table and random stimulus
module tb_seg_scan_ctrl;
  localparam int SCAN  = 4;
  localparam int BLANK = 2;
  localparam int PER   = SCAN + BLANK;
  localparam int FRAME = 8 * PER;
  logic clk = 0, rst = 1, wr_en = 0, commit = 0;
  logic [2:0] wr_addr = 0;
  logic [4:0] wr_data = 0;
  logic [7:0] digit_en = 8'hFF;
  logic [7:0] dig, y;
  logic pend, fd;
  int checks = 0, errors = 0;
  int n = 0, frames = 0;
  logic [4:0] m_sh [8];
  logic [4:0] m_act [8];
  logic m_pend = 0;
  logic [7:0] e_dig;
  logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  typedef struct { logic [4:0] data; logic [7:0] y; } vec_t;
  vec_t tv [7];

  seg_scan_ctrl #(.SCAN_DIV(SCAN), .BLANK_CYC(BLANK)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .digit_en(digit_en), .DIG(dig), .Y(y),
    .commit_pending(pend), .frame_done(fd)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] yref(input logic [4:0] v);
    return ~{v[4], pat[v[3:0]]};
  endfunction

  task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic step();
    int ph, d;
    logic show, bnd;
    logic [7:0] ey;
    logic efd;
    if (rst) begin
      e_dig = 8'hFF; ey = 8'hFF; efd = 0; m_pend = 0; n = 0; frames = 0;
      for (int i = 0; i < 8; i++) begin m_sh[i] = 0; m_act[i] = 0; end
    end else begin
      ph = n % FRAME; d = ph / PER;
      show = (ph % PER) >= BLANK;
      bnd = ph == FRAME - 1;
      e_dig = (show && digit_en[d]) ? ~(8'(1) << d) : 8'hFF;
      ey = (show && digit_en[d]) ? yref(m_act[d]) : 8'hFF;
      efd = bnd;
      if (bnd && m_pend) m_act = m_sh;
      m_pend = commit || (m_pend && !bnd);
      if (wr_en) m_sh[wr_addr] = wr_data;
      if (bnd) frames++;
      n++;
    end
    @(posedge clk); #1;
    chk("DIG", dig, e_dig);
    chk("Y", y, ey);
    chk("frame_done", {7'b0, fd}, {7'b0, efd});
    chk("commit_pending", {7'b0, pend}, {7'b0, m_pend});
  endtask

  task automatic do_reset();
    rst = 1; wr_en = 0; commit = 0; digit_en = 8'hFF;
    repeat (3) step();
    rst = 0;
  endtask

  task automatic run_until(input logic [7:0] target, input int min_frames, input string nm);
    int k = 0;
    do begin step(); k++; end while (!(frames >= min_frames && e_dig == target) && k < 300);
    if (k >= 300) begin
      checks++; errors++;
      $display("FAIL %s timeout got %h want %h", nm, dig, target);
    end
  endtask

  initial begin
    tv[0] = '{5'h00, 8'hC0}; tv[1] = '{5'h01, 8'hF9}; tv[2] = '{5'h08, 8'h80};
    tv[3] = '{5'h0A, 8'h88}; tv[4] = '{5'h0F, 8'h8E}; tv[5] = '{5'h18, 8'h00};
    tv[6] = '{5'h10, 8'h40};
    // reset and first lit slot timing
    do_reset();
    chk("rst_dig", dig, 8'hFF);
    chk("rst_y", y, 8'hFF);
    chk("rst_pend", {7'b0, pend}, 8'h00);
    step(); step();
    chk("pre_show", dig, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("first_dig", dig, 8'hFE);
      chk("first_y", y, 8'hC0);
    end
    step();
    chk("first_off", dig, 8'hFF);
    // load idx values and commit; applied only after the boundary
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_addr = 3'(i); wr_data = 5'(i); step();
    end
    wr_en = 0; commit = 1; step(); commit = 0;
    run_until(8'hFD, 1, "show1");
    chk("show1_y", y, 8'hF9);
    run_until(8'h7F, 1, "show7");
    chk("show7_y", y, 8'hF8);
    // commit in the boundary cycle waits a full frame
    for (int k = 0; k < 60 && n % FRAME != FRAME - 1; k++) step();
    commit = 1; step(); commit = 0;
    chk("cb_pend", {7'b0, pend}, 8'h01);
    repeat (FRAME - 1) step();
    chk("cb_hold", {7'b0, pend}, 8'h01);
    step();
    chk("cb_apply", {7'b0, pend}, 8'h00);
    // digit 2 disabled
    begin
      int hits2 = 0, hits1 = 0;
      digit_en = 8'hFB;
      repeat (FRAME) begin
        step();
        if (dig == 8'hFB) hits2++;
        if (dig == 8'hFD) hits1++;
      end
      chk("en_off_hits", 8'(hits2), 8'd0);
      chk("en_on_hits", 8'(hits1), 8'd4);
      digit_en = 8'hFF;
    end
    // reset mid-SHOW of digit 5 with a pending commit
    commit = 1; step(); commit = 0;
    for (int k = 0; k < 60 && n % FRAME != 5 * PER + 3; k++) step();
    rst = 1; step();
    chk("mid_rst_dig", dig, 8'hFF);
    chk("mid_rst_pend", {7'b0, pend}, 8'h00);
    rst = 0;
    run_until(8'hDF, 0, "post_rst");
    chk("post_rst_y", y, 8'hC0);
    // decode table through a full commit cycle
    for (int i = 0; i < 7; i++) begin
      do_reset();
      wr_en = 1; wr_addr = 0; wr_data = tv[i].data; step();
      wr_en = 0; commit = 1; step(); commit = 0;
      run_until(8'hFE, 1, "tbl");
      chk("tbl_y", y, tv[i].y);
    end
    // random traffic
    do_reset();
    for (int k = 0; k < 2500; k++) begin
      wr_en = $urandom_range(0, 2) == 0;
      wr_addr = 3'($urandom);
      wr_data = 5'($urandom);
      commit = $urandom_range(0, 30) == 0;
      if ($urandom_range(0, 100) == 0) digit_en = 8'($urandom);
      rst = $urandom_range(0, 600) == 0;
      step();
    end
    rst = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
